// File: rtl/im_loader.sv
// Boot-time loader: packs a big-endian byte stream into 32-bit words for the IM and holds the CPU until done.
// Optional trailing XOR checksum byte enabled by defining IM_LOADER_CKSUM_EN.
module im_loader #(
  parameter int NMEM = 20,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] nwords,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_byte,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

`ifdef IM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    CKSUM = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3
  } state_t;
`endif

  localparam logic [AW-1:0] NMEM_W = AW'(NMEM);

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_cnt;
  logic [AW-1:0] nwords_q;
  logic [23:0]   word;
  logic          accept;
  logic          start_ok;

  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state == IDLE) | (state == DONE));

  function automatic logic [31:0] pack_word(input logic [23:0] upper, input logic [7:0] last);
    return {upper, last};
  endfunction

  // Byte shift register: only the first three bytes of a word need storing.
  always_ff @(posedge clk) begin
    if (accept && state == LOAD) begin
      word <= {word[15:0], in_byte};
    end
  end

`ifdef IM_LOADER_CKSUM_EN
  logic [7:0] cksum;

  always_ff @(posedge clk) begin
    if (start_ok) begin
      cksum <= 8'h00;
    end else if (accept && state == LOAD) begin
      cksum <= cksum ^ in_byte;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_waddr <= '0;
      im_wdata <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      nwords_q <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nwords_q <= nwords;
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            if (nwords == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b0;
              cpu_hold <= 1'b0;
            end else if (nwords > NMEM_W) begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
              cpu_hold <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              im_we    <= 1'b1;
              im_waddr <= word_cnt;
              im_wdata <= pack_word(word, in_byte);
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + AW'(1);
          if ((word_cnt + AW'(1)) == nwords_q) begin
`ifdef IM_LOADER_CKSUM_EN
            state    <= CKSUM;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
`ifdef IM_LOADER_CKSUM_EN
        CKSUM: begin
          if (accept) begin
            state    <= DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            err      <= (in_byte != cksum);
          end
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: a byte-level image model predicts IM writes and final status.
module tb_im_loader;
  localparam int NMEM = 20;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] nwords = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_byte = 8'h00;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  im_loader #(.NMEM(NMEM), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nwords(nwords),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] data_q[$];
  logic [7:0] stim_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every IM write must match the next predicted write.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(im_waddr), 32'(e.addr));
        chk("write_data", im_wdata, e.data);
        chk("ready_in_write", 32'(in_ready), 32'd0);
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    data_q.push_back(w[31:24]);
    data_q.push_back(w[23:16]);
    data_q.push_back(w[15:8]);
    data_q.push_back(w[7:0]);
  endtask

  task automatic rand_data(input int nw);
    data_q.delete();
    for (int i = 0; i < 4 * nw; i++) data_q.push_back(8'($urandom));
  endtask

  // mode 0: back-to-back, 1: valid toggles each cycle, 2: random gaps
  task automatic send(input int count, input int mode);
    int sent = 0;
    int budget = 0;
    bit tog = 1'b1;
    while (sent < count && budget < 2000) begin
      @(negedge clk);
      budget++;
      if ((mode == 1 && !tog) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_byte  = stim_q[0];
        if (in_ready) begin
          void'(stim_q.pop_front());
          sent++;
        end
      end
      tog = ~tog;
    end
    if (sent < count) chk("send_timeout", 32'(sent), 32'(count));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic prep_and_start(input int nw, input bit bad_ck, output bit exp_err);
    bit ovf;
    logic [7:0] ck;
    ovf = (nw > NMEM);
    ck = 8'h00;
    exp_err = ovf;
    stim_q.delete();
    if (nw > 0 && !ovf) begin
      for (int w = 0; w < nw; w++) begin
        wr_t e;
        e.addr = AW'(w);
        e.data = {data_q[4*w], data_q[4*w+1], data_q[4*w+2], data_q[4*w+3]};
        exp_q.push_back(e);
      end
      foreach (data_q[i]) begin
        stim_q.push_back(data_q[i]);
        ck ^= data_q[i];
      end
`ifdef IM_LOADER_CKSUM_EN
      stim_q.push_back(bad_ck ? (ck ^ 8'h01) : ck);
      exp_err = bad_ck;
`endif
    end
    @(negedge clk);
    start  = 1'b1;
    nwords = AW'(nw);
    @(negedge clk);
    start = 1'b0;
    if (nw == 0 || ovf) begin
      chk("short_done", 32'(done), 32'd1);
      chk("short_err", 32'(err), 32'(ovf));
      chk("short_hold", 32'(cpu_hold), 32'd0);
    end else begin
      chk("start_hold", 32'(cpu_hold), 32'd1);
      chk("start_done", 32'(done), 32'd0);
      chk("start_ready", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic run_load(input int nw, input int mode, input bit bad_ck, input int intr);
    bit exp_err;
    int n;
    prep_and_start(nw, bad_ck, exp_err);
    if (stim_q.size() > 0) begin
      if (intr >= 0) begin
        send(intr, mode);
        start  = 1'b1;
        nwords = AW'(nw + 3);
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_hold", 32'(cpu_hold), 32'd1);
      end
      send(stim_q.size(), mode);
    end
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("final_done", 32'(done), 32'd1);
    chk("final_err", 32'(err), 32'(exp_err));
    chk("final_hold", 32'(cpu_hold), 32'd0);
    chk("final_ready", 32'(in_ready), 32'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit e;
    #12;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(im_we), 32'd0);
    chk("rst_waddr", 32'(im_waddr), 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    data_q.delete();
    push_word(32'h12345678);
    push_word(32'h9ABCDEF0);
    run_load(2, 0, 1'b0, -1);
    run_load(2, 1, 1'b0, -1);

    data_q.delete();
    run_load(0, 0, 1'b0, -1);
    run_load(21, 0, 1'b0, -1);

    // Stray bytes while DONE must not be taken.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = 8'h5A;
      chk("done_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("done_sticky", 32'(done), 32'd1);

    // Asynchronous reset in the middle of the second word.
    rand_data(3);
    prep_and_start(3, 1'b0, e);
    send(6, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_we", 32'(im_we), 32'd0);
    chk("mid_rst_waddr", 32'(im_waddr), 32'd0);
    chk("mid_rst_wdata", im_wdata, 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_remaining", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    stim_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_data(3);
    run_load(3, 2, 1'b0, -1);

    // start during LOAD is ignored; start from DONE reloads.
    data_q.delete();
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    run_load(2, 2, 1'b0, 2);
    data_q.delete();
    push_word(32'hAABBCCDD);
    run_load(1, 0, 1'b0, -1);

`ifdef IM_LOADER_CKSUM_EN
    data_q.delete();
    push_word(32'h01020408);
    run_load(1, 0, 1'b0, -1);
    run_load(1, 0, 1'b1, -1);
`endif

    for (int it = 0; it < 6; it++) begin
      int nw;
      nw = $urandom_range(1, NMEM);
      rand_data(nw);
      run_load(nw, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
